// File: rtl/mem_stage_ctrl_if.sv
// Bundle of execute-side, data-memory and write-back signals around the MEM stage.
// The slave modport is the stage controller; master is its surrounding pipeline/memory.
interface mem_stage_ctrl_if;
  logic        ex_valid;
  logic        MEM_WE;
  logic        MEM_REG;
  logic        DE_WE;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  modport slave (
    input  ex_valid, MEM_WE, MEM_REG, DE_WE, alu_result, store_data, rd,
    input  dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, err
  );

  modport master (
    output ex_valid, MEM_WE, MEM_REG, DE_WE, alu_result, store_data, rd,
    output dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: passes ALU results through in one cycle and runs
// aligned loads/stores against a data memory with an ack timeout.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst_n,
  mem_stage_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

  logic [0:0]  state_r, state_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [4:0]  rd_r, rd_s;
  logic        store_r, store_s;
  logic        wb_valid_r, wb_valid_s;
  logic        wb_we_r, wb_we_s, wb_we_raw_s;
  logic [4:0]  wb_rd_r, wb_rd_s;
  logic [31:0] wb_data_r, wb_data_s;
  logic        err_r, err_s;
  logic        mem_op_s;

  assign mem_op_s = bus.MEM_WE | bus.MEM_REG;

  // Next-state and write-back result selection
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rd_s        = rd_r;
    store_s     = store_r;
    wb_valid_s  = 1'b0;
    wb_we_raw_s = wb_we_r;
    wb_rd_s     = wb_rd_r;
    wb_data_s   = wb_data_r;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!mem_op_s) begin
            wb_valid_s  = 1'b1;
            wb_we_raw_s = bus.DE_WE;
            wb_rd_s     = bus.rd;
            wb_data_s   = bus.alu_result;
          end else if (bus.alu_result[1:0] == 2'b00) begin
            state_s    = ACCESS;
            wait_cnt_s = 8'd0;
            addr_s     = bus.alu_result;
            wdata_s    = bus.store_data;
            rd_s       = bus.rd;
            store_s    = bus.MEM_WE;
          end else begin
            wb_valid_s  = 1'b1;
            wb_we_raw_s = 1'b0;
            wb_rd_s     = bus.rd;
            err_s       = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        // An ack in the final wait cycle takes priority over the timeout
        if (bus.dmem_ack) begin
          state_s    = IDLE;
          wb_valid_s = 1'b1;
          wb_rd_s    = rd_r;
          if (store_r) begin
            wb_we_raw_s = 1'b0;
            wb_data_s   = 32'd0;
          end else begin
            wb_we_raw_s = 1'b1;
            wb_data_s   = bus.dmem_rdata;
          end
        end else if (wait_cnt_r == TMO_LAST) begin
          state_s     = IDLE;
          wb_valid_s  = 1'b1;
          wb_we_raw_s = 1'b0;
          wb_rd_s     = rd_r;
          err_s       = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    wb_we_s = wb_we_raw_s & (wb_rd_s != 5'd0);
  end

  // State, latched access and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      rd_r       <= 5'd0;
      store_r    <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_we_r    <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      rd_r       <= rd_s;
      store_r    <= store_s;
      wb_valid_r <= wb_valid_s;
      wb_we_r    <= wb_we_s;
      wb_rd_r    <= wb_rd_s;
      wb_data_r  <= wb_data_s;
      err_r      <= err_s;
    end
  end

  assign bus.stall      = (state_r == ACCESS);
  assign bus.dmem_req   = (state_r == ACCESS);
  assign bus.dmem_we    = (state_r == ACCESS) & store_r;
  assign bus.dmem_addr  = addr_r;
  assign bus.dmem_wdata = wdata_r;
  assign bus.wb_valid   = wb_valid_r;
  assign bus.wb_we      = wb_we_r;
  assign bus.wb_rd      = wb_rd_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table of single-cycle ops plus hand-written
// load/store/timeout/reset sequences, with write-back results checked from a queue.
module tb_mem_stage_ctrl;

  typedef struct {
    logic        mem_we;
    logic        mem_reg;
    logic        de_we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_we;
    logic        exp_err;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  vec_t vecs[6];

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
  endtask

  task automatic expect_wb(input logic we, input logic [4:0] rd, input logic [31:0] data,
                           input logic chk_data, input logic err);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.chk_data = chk_data; e.err = err;
    exp_q.push_back(e);
  endtask

  // One clock: inputs already driven at the negedge, outputs sampled at the next negedge
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {31'd0, bus.wb_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_we", {31'd0, bus.wb_we}, {31'd0, e.we});
        check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
        if (e.chk_data) check("wb_data", bus.wb_data, e.data);
        check("err", {31'd0, bus.err}, {31'd0, e.err});
      end
    end else if (bus.err !== 1'b0) begin
      check("err_without_wb", {31'd0, bus.err}, 32'd0);
    end
  endtask

  task automatic drive(input logic v, input logic mw, input logic mr, input logic dw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
    bus.ex_valid = v; bus.MEM_WE = mw; bus.MEM_REG = mr; bus.DE_WE = dw;
    bus.rd = rd; bus.alu_result = alu; bus.store_data = sd;
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 5'd6,  32'h0000_DEAD, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0077, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0102, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd2,  32'h0000_0201, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'd0;
    @(negedge clk);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops: ALU pass-through and misaligned accesses
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].mem_we, vecs[i].mem_reg, vecs[i].de_we, vecs[i].rd, vecs[i].alu, 32'h5A5A_0000);
      expect_wb(vecs[i].exp_we, vecs[i].rd, vecs[i].alu, vecs[i].chk_data, vecs[i].exp_err);
      step();
      check("tbl_stall", {31'd0, bus.stall}, 32'd0);
      check("tbl_req", {31'd0, bus.dmem_req}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    check("hold_wb_rd", {27'd0, bus.wb_rd}, 32'd31);

    // Load acked in the third access cycle; an ALU op waits behind it
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'd0);
    expect_wb(1'b1, 5'd7, 32'hCAFE_F00D, 1'b1, 1'b0);
    step();
    check("ld_req", {31'd0, bus.dmem_req}, 32'd1);
    check("ld_stall", {31'd0, bus.stall}, 32'd1);
    check("ld_addr", bus.dmem_addr, 32'h0000_0100);
    check("ld_we", {31'd0, bus.dmem_we}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0055, 32'd0);
    expect_wb(1'b1, 5'd9, 32'h0000_0055, 1'b1, 1'b0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (n == 3) begin
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hCAFE_F00D;
      end
      step();
      if (bus.dmem_req === 1'b1) n++;
      else break;
    end
    check("ld_req_cycles", n, 32'd3);
    check("ld_stall_after", {31'd0, bus.stall}, 32'd0);
    bus.dmem_ack = 1'b0;
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // Store acked in its first access cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0200, 32'hA5A5_A5A5);
    expect_wb(1'b0, 5'd3, 32'd0, 1'b1, 1'b0);
    step();
    check("st_req", {31'd0, bus.dmem_req}, 32'd1);
    check("st_we", {31'd0, bus.dmem_we}, 32'd1);
    check("st_addr", bus.dmem_addr, 32'h0000_0200);
    check("st_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    bus.dmem_ack = 1'b1;
    step();
    check("st_stall_after", {31'd0, bus.stall}, 32'd0);
    bus.dmem_ack = 1'b0;

    // MEM_WE and MEM_REG together behave as a store
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0210, 32'h0000_0011);
    expect_wb(1'b0, 5'd4, 32'd0, 1'b1, 1'b0);
    step();
    check("both_we", {31'd0, bus.dmem_we}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;

    // Timeout with no ack
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0300, 32'd0);
    expect_wb(1'b0, 5'd8, 32'd0, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      if (bus.dmem_req === 1'b1) n++;
      else break;
    end
    check("tmo_req_cycles", n, 32'd4);

    // Ack in the last allowed cycle wins over the timeout
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0304, 32'd0);
    expect_wb(1'b1, 5'd8, 32'h0BAD_BEEF, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      if (bus.dmem_req === 1'b1) n++;
      else break;
      if (n == 4) begin
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h0BAD_BEEF;
      end
    end
    check("ack4_req_cycles", n, 32'd4);
    bus.dmem_ack = 1'b0;

    // Reset during the second access cycle abandons the load
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0400, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    check("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, bus.dmem_req}, 32'd0);
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    check("arst_addr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // First instruction after reset is accepted normally
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_ABCD, 32'd0);
    expect_wb(1'b1, 5'd12, 32'h0000_ABCD, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of ACCESS-state cycles to wait for dmem_ack (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid, input, 1 bit: the execute stage presents an instruction this cycle.
REQ-005 SHALL have ports MEM_WE, MEM_REG and DE_WE, input, 1 bit each: store, load and register-write controls from the decode controller.
REQ-006 SHALL have port alu_result, input, 32 bits: memory address, or the result for non-memory instructions.
REQ-007 SHALL have port store_data, input, 32 bits, and port rd, input, 5 bits.
REQ-008 SHALL have port stall, output, 1 bit: upstream holds its instruction while stall is high.
REQ-009 SHALL have ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, 32) and dmem_wdata (output, 32).
REQ-010 SHALL have ports dmem_ack (input, 1) and dmem_rdata (input, 32): memory completion and load data, valid while dmem_ack is high.
REQ-011 SHALL have ports wb_valid (output, 1), wb_we (output, 1), wb_rd (output, 5) and wb_data (output, 32): registered write-back results.
REQ-012 SHALL have port err, output, 1 bit: a one-cycle pulse on a misaligned access or a timeout.

Function
REQ-013 SHALL implement the states IDLE and ACCESS; stall SHALL equal (state == ACCESS), combinationally.
REQ-014 In IDLE with ex_valid high and MEM_WE, MEM_REG both low, the block SHALL, on the next edge, set wb_valid=1, wb_we=DE_WE, wb_rd=rd and wb_data=alu_result, and remain in IDLE.
REQ-015 In IDLE with ex_valid high and MEM_WE or MEM_REG high, with alu_result[1:0]==0, the block SHALL latch the address, the store data, rd and the operation type, and enter ACCESS.
REQ-016 If MEM_WE and MEM_REG are both high, the access SHALL be treated as a store.
REQ-017 A memory op with alu_result[1:0]!=0 SHALL NOT access memory; on the next edge the block SHALL set err=1, wb_valid=1 and wb_we=0, and remain in IDLE.
REQ-018 In ACCESS, dmem_req SHALL be 1, and dmem_we, dmem_addr and dmem_wdata SHALL hold their latched values stable until ack or timeout.
REQ-019 In ACCESS, dmem_ack=1 SHALL complete the access on that edge and return the block to IDLE.
REQ-020 A completed load SHALL set wb_valid=1, wb_we=1, wb_rd=latched rd and wb_data=dmem_rdata.
REQ-021 A completed store SHALL set wb_valid=1, wb_we=0 and wb_data=0.
REQ-022 The block SHALL keep an 8-bit wait counter, cleared on entry to ACCESS and incremented each ACCESS cycle without ack.
REQ-023 When the wait counter equals TIMEOUT-1 and dmem_ack is low, the block SHALL return to IDLE on the next edge with err=1, wb_valid=1 and wb_we=0.
REQ-024 An ack arriving in the timeout cycle SHALL win: it is treated as a normal completion and err stays 0.
REQ-025 wb_we SHALL be forced to 0 whenever wb_rd==0.
REQ-026 wb_valid and err SHALL be single-cycle pulses, one wb_valid per accepted instruction; the other wb_* outputs SHALL hold their values between pulses.
REQ-027 dmem_ack in IDLE SHALL be ignored, and ex_* inputs in ACCESS SHALL be ignored.
REQ-028 Back-to-back non-memory instructions SHALL sustain one wb_valid per cycle with zero stall.
REQ-029 Memory-op latency SHALL be (ack cycle + 1): stall deasserts the cycle after the ack edge, and the next instruction is accepted in that cycle.

Reset
REQ-030 While rst_n==0, asynchronously and regardless of clk, state SHALL be IDLE, the wait counter 0, and stall, dmem_req, dmem_we, wb_valid, wb_we and err all 0.
REQ-031 While rst_n==0, dmem_addr, dmem_wdata, wb_rd and wb_data SHALL all be 0.
REQ-032 A reset asserted during ACCESS SHALL drop dmem_req immediately, and the pending access SHALL produce no wb_valid.
REQ-033 After reset deassertion, the first edge with ex_valid high SHALL be accepted normally.

Verification
REQ-034 ALU op: ex_valid=1, DE_WE=1, rd=5, alu_result=0x1234 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, stall=0.
REQ-035 Load: MEM_REG=1, rd=7, addr=0x100, ack after 3 cycles with rdata=0xCAFEF00D -> dmem_req held for 3 cycles, then wb_data=0xCAFEF00D, wb_we=1, and stall low the following cycle.
REQ-036 Store: MEM_WE=1, addr=0x200, store_data=0xA5A5A5A5, ack in the first ACCESS cycle -> dmem_we=1 with stable address and data, then wb_valid=1 and wb_we=0.
REQ-037 Misaligned load at addr=0x102 -> dmem_req never asserts; err=1 and wb_valid=1 with wb_we=0 on the next cycle.
REQ-038 TIMEOUT=4 with no ack -> dmem_req high for exactly 4 cycles, then err=1 and wb_valid=1; a repeat with ack in cycle 4 -> normal completion and err=0.
REQ-039 rst_n pulsed low during the second ACCESS cycle -> dmem_req and stall go to 0 without a clock edge, and no wb_valid follows.
